// File: rtl/cpu_defs.sv
// Shared definitions for the SimpleCPU pipeline controller: exception codes,
// exception vectors, redirect FSM encoding and bus-width macros.
`ifndef CPU_DEFS_SV
`define CPU_DEFS_SV

`define DATA_BUS [DATA_WIDTH-1:0]
`define PREG_BUS [PREG_WIDTH-1:0]

package cpu_defs;

  localparam logic [31:0] EXCEPT_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_INT      = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_SYSCALL  = 32'h0000_0002;
  localparam logic [31:0] EXCEPT_BREAK    = 32'h0000_0003;
  localparam logic [31:0] EXCEPT_OVERFLOW = 32'h0000_0004;
  localparam logic [31:0] EXCEPT_ERET     = 32'h0000_0005;

  localparam logic [31:0] EXCEPT_INT_ADDR      = 32'h0000_0200;
  localparam logic [31:0] EXCEPT_SYSCALL_ADDR  = 32'h0000_0180;
  localparam logic [31:0] EXCEPT_BREAK_ADDR    = 32'h0000_0190;
  localparam logic [31:0] EXCEPT_OVERFLOW_ADDR = 32'h0000_01a0;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } redir_state_e;

endpackage

`endif

// File: rtl/hazard_match.sv
// Load-use detector: compares every decode source operand against every
// in-flight load destination that cannot yet be forwarded.
module hazard_match #(
  parameter int NUM_SRC    = 2,
  parameter int LU_DEPTH   = 1,
  parameter int PREG_WIDTH = 6
) (
  input  logic [NUM_SRC-1:0]             src_en,
  input  logic [NUM_SRC*PREG_WIDTH-1:0]  src_addr,
  input  logic [LU_DEPTH-1:0]            ld_wb,
  input  logic [LU_DEPTH*PREG_WIDTH-1:0] ld_addr,
  output logic                           load_use
);

  logic `PREG_BUS src_a;
  logic `PREG_BUS ld_a;

  // OR of all source/load address matches over the full comparator array
  always_comb begin
    load_use = 1'b0;
    src_a    = '0;
    ld_a     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < LU_DEPTH; j++) begin
        src_a = src_addr[k*PREG_WIDTH +: PREG_WIDTH];
        ld_a  = ld_addr[j*PREG_WIDTH +: PREG_WIDTH];
        if (src_en[k] && ld_wb[j] && (src_a == ld_a)) begin
          load_use = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and redirect controller for the in-order pipeline: per-stage
// stall/flush, fetch redirect with exception priority, fetch drain and a
// saturating load-use stall counter.
module pipeline_ctrl
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 5,
  parameter int PREG_WIDTH = 6,
  parameter int NUM_SRC    = 2,
  parameter int BR_STAGE   = 2,
  parameter int LU_DEPTH   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  input  logic [STAGES-1:0]              stage_busy,
  input  logic                           dec_extra_stall,
  input  logic [NUM_SRC-1:0]             dec_src_en,
  input  logic [NUM_SRC*PREG_WIDTH-1:0]  dec_src_addr,
  input  logic                           dec_branch,
  input  logic [LU_DEPTH-1:0]            ld_wb,
  input  logic [LU_DEPTH*PREG_WIDTH-1:0] ld_addr,
  input  logic                           br_take,
  input  logic `DATA_BUS                 br_target,
  input  logic `DATA_BUS                 exception,
  input  logic `DATA_BUS                 cp0_epc,
  output logic [STAGES-1:0]              stall,
  output logic [STAGES-1:0]              flush,
  output logic                           global_flush,
  output logic                           redirect_valid,
  output logic `DATA_BUS                 redirect_target,
  output logic [CNT_WIDTH-1:0]           lu_stall_cnt
);

  localparam logic `DATA_BUS NO_EXC = DATA_WIDTH'(EXCEPT_NONE);

  // Maps an exception code to its handler vector; ERET returns to EPC.
  function automatic logic `DATA_BUS exc_vector(input logic `DATA_BUS code,
                                                input logic `DATA_BUS epc);
    case (code)
      DATA_WIDTH'(EXCEPT_INT):      exc_vector = DATA_WIDTH'(EXCEPT_INT_ADDR);
      DATA_WIDTH'(EXCEPT_SYSCALL):  exc_vector = DATA_WIDTH'(EXCEPT_SYSCALL_ADDR);
      DATA_WIDTH'(EXCEPT_BREAK):    exc_vector = DATA_WIDTH'(EXCEPT_BREAK_ADDR);
      DATA_WIDTH'(EXCEPT_OVERFLOW): exc_vector = DATA_WIDTH'(EXCEPT_OVERFLOW_ADDR);
      DATA_WIDTH'(EXCEPT_ERET):     exc_vector = epc;
      default:                      exc_vector = '0;
    endcase
  endfunction

  redir_state_e           state_q, state_d;
  logic `DATA_BUS         pend_target_q, pend_target_d;
  logic                   drain_q, drain_d;
  logic                   global_flush_q, global_flush_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   load_use;
  logic                   hazard_dec;

  hazard_match #(
    .NUM_SRC    (NUM_SRC),
    .LU_DEPTH   (LU_DEPTH),
    .PREG_WIDTH (PREG_WIDTH)
  ) u_hazard_match (
    .src_en   (dec_src_en),
    .src_addr (dec_src_addr),
    .ld_wb    (ld_wb),
    .ld_addr  (ld_addr),
    .load_use (load_use)
  );

  assign hazard_dec = load_use | (dec_branch & stage_busy[0]) | dec_extra_stall;

  // Stall propagates backwards from write-back; bubbles enter where a stalled
  // stage feeds a moving one, then branch/drain/global kills are overlaid.
  always_comb begin
    stall = '1;
    flush = '1;
    if (run) begin
      stall[STAGES-1] = stage_busy[STAGES-1];
      for (int i = STAGES-2; i >= 0; i--) begin
        stall[i] = stage_busy[i] | stall[i+1] | ((i == 1) ? hazard_dec : 1'b0);
      end
      for (int i = 0; i < STAGES-1; i++) begin
        flush[i] = stall[i] & ~stall[i+1];
      end
      flush[STAGES-1] = stage_busy[STAGES-1];
      if (br_take) begin
        flush[BR_STAGE-1:0] = '1;
      end
      if (drain_q) begin
        flush[0] = 1'b1;
      end
      if (global_flush_q) begin
        flush = '1;
      end
    end
  end

  // Next state for redirect FSM, drain flag, global flush pulse and counter;
  // everything holds while the core is not running.
  always_comb begin
    state_d        = state_q;
    pend_target_d  = pend_target_q;
    drain_d        = drain_q;
    global_flush_d = 1'b0;
    cnt_d          = cnt_q;
    if (run) begin
      global_flush_d = (exception != NO_EXC);
      if (exception != NO_EXC) begin
        state_d       = PENDING;
        pend_target_d = exc_vector(exception, cp0_epc);
      end else if ((state_q == IDLE) && br_take && stall[0]) begin
        state_d       = PENDING;
        pend_target_d = br_target;
      end else if ((state_q == PENDING) && !stall[0]) begin
        state_d = IDLE;
      end

      if (global_flush_q) begin
        drain_d = 1'b0;
      end else if (br_take && stage_busy[0]) begin
        drain_d = 1'b1;
      end else if (drain_q && !stage_busy[0]) begin
        drain_d = 1'b0;
      end

      if (load_use && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pend_target_q  <= '0;
      drain_q        <= 1'b0;
      global_flush_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      pend_target_q  <= pend_target_d;
      drain_q        <= drain_d;
      global_flush_q <= global_flush_d;
      cnt_q          <= cnt_d;
    end
  end

  assign global_flush    = global_flush_q;
  assign redirect_valid  = br_take | (state_q == PENDING);
  assign redirect_target = (state_q == PENDING) ? pend_target_q : br_target;
  assign lu_stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver applies directed and random
// cycles, a reference model predicts every output and queues it, and a
// monitor on the falling edge compares the DUT against the queue.
module tb_pipeline_ctrl;
  import cpu_defs::*;

  localparam int DW = 32;
  localparam int S  = 5;
  localparam int PW = 6;
  localparam int NS = 2;
  localparam int BR = 2;
  localparam int LD = 2;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, run, dec_extra_stall, dec_branch, br_take;
  logic [S-1:0]     stage_busy;
  logic [NS-1:0]    dec_src_en;
  logic [NS*PW-1:0] dec_src_addr;
  logic [LD-1:0]    ld_wb;
  logic [LD*PW-1:0] ld_addr;
  logic [DW-1:0]    br_target, exception, cp0_epc;
  logic [S-1:0]     stall, flush;
  logic             global_flush, redirect_valid;
  logic [DW-1:0]    redirect_target;
  logic [CW-1:0]    lu_stall_cnt;

  pipeline_ctrl #(
    .DATA_WIDTH(DW), .STAGES(S), .PREG_WIDTH(PW), .NUM_SRC(NS),
    .BR_STAGE(BR), .LU_DEPTH(LD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .stage_busy(stage_busy),
    .dec_extra_stall(dec_extra_stall), .dec_src_en(dec_src_en),
    .dec_src_addr(dec_src_addr), .dec_branch(dec_branch), .ld_wb(ld_wb),
    .ld_addr(ld_addr), .br_take(br_take), .br_target(br_target),
    .exception(exception), .cp0_epc(cp0_epc), .stall(stall), .flush(flush),
    .global_flush(global_flush), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [S-1:0]  stall;
    logic [S-1:0]  flush;
    logic          gf;
    logic          rv;
    logic [DW-1:0] rt;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   pushes = 0;
  int   cyc_no = 0;
  logic done = 1'b0;

  // Reference model state: "current" (m_) and "after the next edge" (n_)
  logic          m_pend, n_pend;
  logic [DW-1:0] m_tgt, n_tgt;
  logic          m_drain, n_drain;
  logic          m_gf, n_gf;
  int            m_cnt, n_cnt;

  function automatic logic [DW-1:0] vec(input logic [DW-1:0] code, input logic [DW-1:0] epc);
    if (code == EXCEPT_INT)      return EXCEPT_INT_ADDR;
    if (code == EXCEPT_SYSCALL)  return EXCEPT_SYSCALL_ADDR;
    if (code == EXCEPT_BREAK)    return EXCEPT_BREAK_ADDR;
    if (code == EXCEPT_OVERFLOW) return EXCEPT_OVERFLOW_ADDR;
    if (code == EXCEPT_ERET)     return epc;
    return '0;
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc_no++;
    m_pend = n_pend; m_tgt = n_tgt; m_drain = n_drain; m_gf = n_gf; m_cnt = n_cnt;
    rst = 1'b0; run = 1'b1; stage_busy = '0; dec_extra_stall = 1'b0;
    dec_src_en = '0; dec_src_addr = '0; dec_branch = 1'b0; ld_wb = '0;
    ld_addr = '0; br_take = 1'b0; br_target = '0; exception = EXCEPT_NONE;
    cp0_epc = '0;
  endtask

  task automatic end_cycle();
    exp_t e;
    logic lu, hz1;
    logic [S-1:0] s, f;
    lu = 1'b0;
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < LD; j++)
        if (dec_src_en[k] && ld_wb[j] && dec_src_addr[k*PW +: PW] == ld_addr[j*PW +: PW])
          lu = 1'b1;
    hz1 = lu | (dec_branch & stage_busy[0]) | dec_extra_stall;
    // A stage stalls if it or anything downstream is busy or hazarded
    for (int i = 0; i < S; i++) begin
      s[i] = 1'b0;
      for (int j = i; j < S; j++)
        if (stage_busy[j] || (j == 1 && hz1)) s[i] = 1'b1;
    end
    for (int i = 0; i < S-1; i++) f[i] = s[i] & ~s[i+1];
    f[S-1] = stage_busy[S-1];
    if (br_take) for (int i = 0; i < BR; i++) f[i] = 1'b1;
    if (m_drain) f[0] = 1'b1;
    if (m_gf) f = '1;
    if (!run) begin s = '1; f = '1; end
    e.stall = s; e.flush = f; e.gf = m_gf;
    e.rv = br_take | m_pend;
    e.rt = m_pend ? m_tgt : br_target;
    e.cnt = CW'(m_cnt);
    e.cyc = cyc_no;
    q.push_back(e);
    pushes++;

    n_pend = m_pend; n_tgt = m_tgt; n_drain = m_drain; n_gf = 1'b0; n_cnt = m_cnt;
    if (rst) begin
      n_pend = 1'b0; n_tgt = '0; n_drain = 1'b0; n_gf = 1'b0; n_cnt = 0;
    end else if (run) begin
      n_gf = (exception != EXCEPT_NONE);
      if (n_gf) begin
        n_pend = 1'b1; n_tgt = vec(exception, cp0_epc);
      end else if (!m_pend && br_take && s[0]) begin
        n_pend = 1'b1; n_tgt = br_target;
      end else if (m_pend && !s[0]) begin
        n_pend = 1'b0;
      end
      if (m_gf) n_drain = 1'b0;
      else if (br_take && stage_busy[0]) n_drain = 1'b1;
      else if (m_drain && !stage_busy[0]) n_drain = 1'b0;
      if (lu && m_cnt < MAXC) n_cnt = m_cnt + 1;
    end
  endtask

  // Monitor: compares every queued prediction on the falling edge
  int passed = 0;
  int total  = 0;
  int pops   = 0;

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      pops++;
      chk("stall", e.cyc, 64'(stall), 64'(e.stall));
      chk("flush", e.cyc, 64'(flush), 64'(e.flush));
      chk("global_flush", e.cyc, 64'(global_flush), 64'(e.gf));
      chk("redirect_valid", e.cyc, 64'(redirect_valid), 64'(e.rv));
      chk("redirect_target", e.cyc, 64'(redirect_target), 64'(e.rt));
      chk("lu_stall_cnt", e.cyc, 64'(lu_stall_cnt), 64'(e.cnt));
    end
    if (done) begin
      chk("all_predictions_checked", cyc_no, 64'(pops), 64'(pushes));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  initial begin
    int r;
    rst = 1'b1; run = 1'b1; stage_busy = '0; dec_extra_stall = 1'b0;
    dec_src_en = '0; dec_src_addr = '0; dec_branch = 1'b0; ld_wb = '0;
    ld_addr = '0; br_take = 1'b0; br_target = '0; exception = EXCEPT_NONE;
    cp0_epc = '0;
    n_pend = 1'b0; n_tgt = '0; n_drain = 1'b0; n_gf = 1'b0; n_cnt = 0;

    // reset state
    repeat (2) begin begin_cycle(); rst = 1'b1; end_cycle(); end

    // load-use hit, then miss
    begin_cycle(); ld_wb = 2'b01; ld_addr = {6'd0, 6'd5};
    dec_src_en = 2'b01; dec_src_addr = {6'd0, 6'd5}; end_cycle();
    begin_cycle(); ld_wb = 2'b01; ld_addr = {6'd0, 6'd5};
    dec_src_en = 2'b01; dec_src_addr = {6'd0, 6'd6}; end_cycle();

    // backpressure from stage 3
    repeat (3) begin begin_cycle(); stage_busy = 5'b01000; end_cycle(); end

    // branch with fetch ready
    begin_cycle(); br_take = 1'b1; br_target = 32'h400; end_cycle();
    begin_cycle(); end_cycle();

    // branch with fetch busy, busy for two cycles then released
    begin_cycle(); br_take = 1'b1; br_target = 32'h400; stage_busy = 5'b00001; end_cycle();
    begin_cycle(); stage_busy = 5'b00001; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();

    // exception while pending a branch, then ERET
    begin_cycle(); br_take = 1'b1; br_target = 32'h400; stage_busy = 5'b00001; end_cycle();
    begin_cycle(); stage_busy = 5'b00001; exception = EXCEPT_SYSCALL; end_cycle();
    begin_cycle(); stage_busy = 5'b00001; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); exception = EXCEPT_ERET; cp0_epc = 32'h1234; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();

    // halted with a load-use present: everything frozen
    repeat (2) begin
      begin_cycle(); run = 1'b0; ld_wb = 2'b10; ld_addr = {6'd9, 6'd0};
      dec_src_en = 2'b10; dec_src_addr = {6'd9, 6'd0}; end_cycle();
    end

    // reset while pending drops the redirect
    begin_cycle(); br_take = 1'b1; br_target = 32'h800; stage_busy = 5'b00001; end_cycle();
    begin_cycle(); rst = 1'b1; stage_busy = 5'b00001; end_cycle();
    begin_cycle(); br_take = 1'b1; br_target = 32'h40; end_cycle();
    begin_cycle(); end_cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      begin_cycle();
      rst = ($urandom_range(0, 63) == 0);
      run = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < S; i++) stage_busy[i] = ($urandom_range(0, 4) == 0);
      dec_extra_stall = ($urandom_range(0, 7) == 0);
      dec_branch = ($urandom_range(0, 3) == 0);
      dec_src_en = NS'($urandom);
      for (int k = 0; k < NS; k++) dec_src_addr[k*PW +: PW] = PW'($urandom_range(0, 3));
      ld_wb = LD'($urandom);
      for (int j = 0; j < LD; j++) ld_addr[j*PW +: PW] = PW'($urandom_range(0, 3));
      br_take = ($urandom_range(0, 3) == 0);
      br_target = $urandom;
      cp0_epc = $urandom;
      r = $urandom_range(0, 31);
      exception = (r < 26) ? EXCEPT_NONE : DW'(r - 25);
      end_cycle();
    end

    begin_cycle();
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_timeout: monitor did not finish, got no summary expected summary");
    $fatal(1);
  end

endmodule
